// File: rtl/shared_mem_pkg.sv
// rtl/shared_mem_pkg.sv - shared scratchpad types and constants used by the per-port controllers
package shared_mem_pkg;

  localparam int ADDR_W = 24;
  localparam int BLK    = 5;

  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ_RD  = 3'd1,
    REQ_WR  = 3'd2,
    RD_WAIT = 3'd3,
    RESP    = 3'd4
  } mem_port_state_e;

endpackage

// File: rtl/mem_port_ctrl.sv
// rtl/mem_port_ctrl.sv - per-processor front end: one load/store at a time into the shared scratchpad
module mem_port_ctrl
  import shared_mem_pkg::*;
#(
  parameter int BUS_SIZE  = 160,
  parameter int UNIT_SIZE = 32,
  parameter int ADDR_SIZE = 24,
  parameter int RD_LAT    = 1,
  parameter int CNT_W     = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_cmd_valid,
  output logic                 o_cmd_ready,
  input  logic                 i_cmd_we,
  input  logic [ADDR_SIZE-1:0] i_cmd_addr,
  input  logic [BUS_SIZE-1:0]  i_cmd_wdata,
  input  logic [2:0]           i_cmd_wr_size,
  output logic                 o_rsp_valid,
  input  logic                 i_rsp_ready,
  output logic [BUS_SIZE-1:0]  o_rsp_rdata,
  output logic                 o_rsp_err,
  output logic                 o_req_rd,
  output logic                 o_req_wr,
  input  logic                 i_grant_rd,
  input  logic                 i_grant_wr,
  output logic [ADDR_SIZE-1:0] o_mem_addr,
  output logic [BUS_SIZE-1:0]  o_mem_wdata,
  output logic [2:0]           o_mem_wr_size,
  output logic                 o_mem_wr_en,
  input  logic [BUS_SIZE-1:0]  i_mem_rd_data,
  output logic [CNT_W-1:0]     o_stall_cnt
);

  localparam int UNITS = BUS_SIZE / UNIT_SIZE;
  localparam int LAT_W = $clog2(RD_LAT + 1);
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  mem_port_state_e state, next_state;

  logic [ADDR_SIZE-1:0] addr_q;
  logic [BUS_SIZE-1:0]  wdata_q;
  logic [2:0]           size_q;
  logic [BUS_SIZE-1:0]  rdata_q;
  logic                 err_q;
  logic [LAT_W-1:0]     lat_cnt;
  logic [CNT_W-1:0]     stall_cnt;

  logic size_ok;
  logic accept;
  logic hit_rd;
  logic hit_wr;
  logic waiting;
  logic rd_capture;

  assign size_ok    = (i_cmd_wr_size != 3'd0) && (int'(i_cmd_wr_size) <= UNITS);
  assign accept     = i_cmd_valid && (state == IDLE);
  assign hit_rd     = (state == REQ_RD) && i_grant_rd;
  assign hit_wr     = (state == REQ_WR) && i_grant_wr;
  assign waiting    = ((state == REQ_RD) && !i_grant_rd) || ((state == REQ_WR) && !i_grant_wr);
  assign rd_capture = (state == RD_WAIT) && (lat_cnt == '0);

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (i_cmd_valid) begin
          if (!i_cmd_we)    next_state = REQ_RD;
          else if (size_ok) next_state = REQ_WR;
          else              next_state = RESP;
        end
      end
      REQ_RD:  if (i_grant_rd)      next_state = RD_WAIT;
      REQ_WR:  if (i_grant_wr)      next_state = RESP;
      RD_WAIT: if (lat_cnt == '0)   next_state = RESP;
      RESP:    if (i_rsp_ready)     next_state = IDLE;
      default:                      next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      size_q    <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      lat_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      state <= next_state;
      if (accept) begin
        addr_q  <= i_cmd_addr;
        wdata_q <= i_cmd_wdata;
        size_q  <= i_cmd_wr_size;
        rdata_q <= '0;
        err_q   <= i_cmd_we && !size_ok;
      end
      // grant cycle counts as cycle 0, so the counter starts at RD_LAT-1
      if (hit_rd)
        lat_cnt <= LAT_LOAD;
      else if ((state == RD_WAIT) && (lat_cnt != '0))
        lat_cnt <= lat_cnt - LAT_W'(1);
      if (rd_capture)
        rdata_q <= i_mem_rd_data;
      if (waiting && (stall_cnt != CNT_MAX))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign o_cmd_ready   = (state == IDLE);
  assign o_req_rd      = (state == REQ_RD);
  assign o_req_wr      = (state == REQ_WR);
  // a reset arriving with the grant must not leak a write strobe
  assign o_mem_wr_en   = hit_wr && !i_rst;
  assign o_rsp_valid   = (state == RESP);
  assign o_rsp_rdata   = rdata_q;
  assign o_rsp_err     = err_q;
  assign o_mem_addr    = addr_q;
  assign o_mem_wdata   = wdata_q;
  assign o_mem_wr_size = size_q;
  assign o_stall_cnt   = stall_cnt;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// tb/tb_mem_port_ctrl.sv - self-checking bench for mem_port_ctrl with scratchpad model
module tb_mem_port_ctrl;

  localparam int BUS = 160;
  localparam int AW  = 24;
  localparam int LAT = 1;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
  logic [AW-1:0]  cmd_addr = '0;
  logic [BUS-1:0] cmd_wdata = '0;
  logic [2:0]     cmd_wr_size = '0;
  logic           rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [BUS-1:0] rsp_rdata;
  logic           req_rd, req_wr, grant_rd = 1'b0, grant_wr = 1'b0;
  logic [AW-1:0]  mem_addr;
  logic [BUS-1:0] mem_wdata;
  logic [2:0]     mem_wr_size;
  logic           mem_wr_en;
  logic [BUS-1:0] mem_rd_data = '0;
  logic [15:0]    stall_cnt;

  logic           s_cmd_valid = 1'b0, s_cmd_ready, s_rsp_valid, s_rsp_ready = 1'b0, s_rsp_err;
  logic [BUS-1:0] s_rsp_rdata, s_mem_wdata;
  logic           s_req_rd, s_req_wr, s_grant_wr = 1'b0, s_mem_wr_en;
  logic [AW-1:0]  s_mem_addr;
  logic [2:0]     s_mem_wr_size;
  logic [3:0]     s_stall_cnt;

  int total = 0;
  int bad   = 0;
  int stall_model = 0;
  logic [BUS-1:0] model_mem [logic [AW-1:0]];
  logic [BUS-1:0] env_mem   [logic [AW-1:0]];

  always #5 clk = ~clk;

  mem_port_ctrl #(.BUS_SIZE(BUS), .UNIT_SIZE(32), .ADDR_SIZE(AW), .RD_LAT(LAT), .CNT_W(16)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_we(cmd_we), .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata), .i_cmd_wr_size(cmd_wr_size),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err),
    .o_req_rd(req_rd), .o_req_wr(req_wr), .i_grant_rd(grant_rd), .i_grant_wr(grant_wr),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_wr_size(mem_wr_size),
    .o_mem_wr_en(mem_wr_en), .i_mem_rd_data(mem_rd_data), .o_stall_cnt(stall_cnt)
  );

  mem_port_ctrl #(.BUS_SIZE(BUS), .UNIT_SIZE(32), .ADDR_SIZE(AW), .RD_LAT(LAT), .CNT_W(4)) u_sat (
    .i_clk(clk), .i_rst(rst), .i_cmd_valid(s_cmd_valid), .o_cmd_ready(s_cmd_ready),
    .i_cmd_we(1'b1), .i_cmd_addr(24'h20), .i_cmd_wdata({5{32'hA5A5_0001}}), .i_cmd_wr_size(3'd5),
    .o_rsp_valid(s_rsp_valid), .i_rsp_ready(s_rsp_ready), .o_rsp_rdata(s_rsp_rdata), .o_rsp_err(s_rsp_err),
    .o_req_rd(s_req_rd), .o_req_wr(s_req_wr), .i_grant_rd(1'b0), .i_grant_wr(s_grant_wr),
    .o_mem_addr(s_mem_addr), .o_mem_wdata(s_mem_wdata), .o_mem_wr_size(s_mem_wr_size),
    .o_mem_wr_en(s_mem_wr_en), .i_mem_rd_data('0), .o_stall_cnt(s_stall_cnt)
  );

  task automatic chk(input string nm, input logic [BUS-1:0] act, input logic [BUS-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [BUS-1:0] garbage();
    return {$urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // a store replaces the lowest wr_size 32-bit units of the word
  function automatic logic [BUS-1:0] merge(input logic [BUS-1:0] old, input logic [BUS-1:0] nw,
                                           input logic [2:0] sz);
    logic [BUS-1:0] r;
    r = old;
    for (int u = 0; u < 5; u++)
      if (u < int'(sz)) r[u*32 +: 32] = nw[u*32 +: 32];
    return r;
  endfunction

  task automatic txn(input logic we, input logic [AW-1:0] a, input logic [BUS-1:0] d,
                     input logic [2:0] sz, input int gdly, input int rdly, input logic ill);
    logic [BUS-1:0] exp_rd, held, old;
    int lat, exp_lat;
    exp_rd = '0;
    if (!we) exp_rd = model_mem.exists(a) ? model_mem[a] : '0;
    if (!ill) stall_model = (stall_model + gdly > 65535) ? 65535 : stall_model + gdly;
    exp_lat = ill ? 1 : (we ? 2 + gdly : 2 + LAT + gdly);

    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1; cmd_we = we; cmd_addr = a; cmd_wdata = d; cmd_wr_size = sz;
    tick();
    cmd_valid = 0; cmd_addr = 24'($urandom); cmd_wdata = garbage(); cmd_wr_size = 3'($urandom);
    lat = 1;
    if (ill) begin
      chk("ill_no_req_wr", req_wr, 0);
      chk("ill_no_wr_en", mem_wr_en, 0);
    end else begin
      chk("req_raised", we ? req_wr : req_rd, 1);
      chk("mem_addr", mem_addr, a);
      for (int i = 0; i < gdly; i++) begin
        if (we) grant_rd = 1'($urandom); else grant_wr = 1'($urandom);
        #1;
        chk("wait_no_wr_en", mem_wr_en, 0);
        chk("wait_req_held", we ? req_wr : req_rd, 1);
        tick();
        lat++;
      end
      if (we) begin grant_wr = 1; grant_rd = 1'($urandom); end
      else    begin grant_rd = 1; grant_wr = 1'($urandom); end
      #1;
      if (we) begin
        chk("wr_en_grant", mem_wr_en, 1);
        chk("mem_wdata", mem_wdata, d);
        chk("mem_wr_size", mem_wr_size, sz);
        old = env_mem.exists(mem_addr) ? env_mem[mem_addr] : '0;
        env_mem[mem_addr] = merge(old, mem_wdata, mem_wr_size);
      end else begin
        chk("rd_no_wr_en", mem_wr_en, 0);
      end
      tick();
      lat++;
      grant_wr = 0; grant_rd = 0;
      if (!we) begin
        for (int c = 1; c <= LAT; c++) begin
          chk("req_rd_dropped", req_rd, 0);
          chk("rd_wait_addr", mem_addr, a);
          if (c == LAT) mem_rd_data = env_mem.exists(mem_addr) ? env_mem[mem_addr] : '0;
          else          mem_rd_data = garbage();
          tick();
          lat++;
        end
        mem_rd_data = garbage();
      end
    end
    while (!rsp_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk("rsp_latency", lat, exp_lat);
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_err", rsp_err, ill);
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("resp_cmd_ready", cmd_ready, 0);
    chk("resp_reqs_low", {req_rd, req_wr}, 0);
    chk("stall_cnt", stall_cnt, stall_model);
    held = rsp_rdata;
    for (int i = 0; i < rdly; i++) begin
      grant_wr = 1'($urandom); grant_rd = 1'($urandom);
      #1;
      chk("resp_no_wr_en", mem_wr_en, 0);
      tick();
      chk("hold_rsp_valid", rsp_valid, 1);
      chk("hold_rdata", rsp_rdata, held);
      chk("hold_cmd_ready", cmd_ready, 0);
    end
    grant_wr = 0; grant_rd = 0;
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    chk("rsp_done", rsp_valid, 0);
    chk("back_idle", cmd_ready, 1);
    if (we && !ill) begin
      old = model_mem.exists(a) ? model_mem[a] : '0;
      model_mem[a] = merge(old, d, sz);
    end
  endtask

  typedef struct {
    logic           we;
    logic [AW-1:0]  addr;
    logic [BUS-1:0] data;
    logic [2:0]     size;
    int             gdly;
    int             rdly;
    logic           exp_err;
  } vec_t;

  vec_t vt[9];

  initial begin
    vt[0] = '{1'b1, 24'h10, {32'h1111_0005, 32'h2222_0004, 32'h3333_0003, 32'h4444_0002, 32'h5555_0001}, 3'd5, 3, 0, 1'b0};
    vt[1] = '{1'b0, 24'h10, '0, 3'd0, 0, 0, 1'b0};
    vt[2] = '{1'b1, 24'h11, {5{32'hDEAD_BEEF}}, 3'd0, 0, 0, 1'b1};
    vt[3] = '{1'b1, 24'h11, {5{32'hCAFE_F00D}}, 3'd6, 0, 1, 1'b1};
    vt[4] = '{1'b0, 24'h11, '0, 3'd0, 1, 4, 1'b0};
    vt[5] = '{1'b1, 24'h12, {5{32'h0BAD_C0DE}}, 3'd2, 0, 0, 1'b0};
    vt[6] = '{1'b0, 24'h12, '0, 3'd0, 2, 1, 1'b0};
    vt[7] = '{1'b1, 24'h10, {5{32'h7777_7777}}, 3'd1, 1, 0, 1'b0};
    vt[8] = '{1'b0, 24'h10, '0, 3'd0, 0, 2, 1'b0};

    mem_rd_data = garbage();
    rst = 1;
    tick(); tick();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_reqs", {req_rd, req_wr, mem_wr_en}, 0);
    chk("rst_rsp", {rsp_valid, rsp_err}, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_wr_size", mem_wr_size, 0);
    chk("rst_stall", stall_cnt, 0);
    rst = 0;
    tick();

    for (int i = 0; i < 9; i++)
      txn(vt[i].we, vt[i].addr, vt[i].data, vt[i].size, vt[i].gdly, vt[i].rdly, vt[i].exp_err);

    grant_wr = 1; grant_rd = 1;
    #1;
    chk("idle_spurious_wr_en", mem_wr_en, 0);
    tick();
    grant_wr = 0; grant_rd = 0;
    chk("idle_spurious_state", {cmd_ready, req_rd, req_wr, rsp_valid}, 4'b1000);

    for (int i = 0; i < 30; i++) begin
      logic           we;
      logic [2:0]     sz;
      we = 1'($urandom);
      sz = 3'($urandom_range(0, 7));
      txn(we, 24'h10 + 24'($urandom_range(0, 3)), garbage(), sz,
          $urandom_range(0, 4), $urandom_range(0, 3), we && (sz == 0 || sz > 5));
    end

    cmd_valid = 1; cmd_we = 1; cmd_addr = 24'h13; cmd_wdata = garbage(); cmd_wr_size = 3'd3;
    tick();
    cmd_valid = 0;
    chk("pre_rst_req_wr", req_wr, 1);
    grant_wr = 1; rst = 1;
    #1;
    chk("rst_grant_no_wr_en", mem_wr_en, 0);
    tick();
    chk("abort_reqs", {req_rd, req_wr, mem_wr_en}, 0);
    chk("abort_rsp", {rsp_valid, rsp_err}, 0);
    chk("abort_cmd_ready", cmd_ready, 1);
    chk("abort_mem_addr", mem_addr, 0);
    chk("abort_mem_wdata", mem_wdata, 0);
    chk("abort_wr_size", mem_wr_size, 0);
    chk("abort_stall", stall_cnt, 0);
    chk("abort_rdata", rsp_rdata, 0);
    rst = 0; grant_wr = 0;
    stall_model = 0;
    tick();
    chk("abort_idle_after", {cmd_ready, rsp_valid}, 2'b10);

    s_cmd_valid = 1;
    tick();
    s_cmd_valid = 0;
    for (int i = 0; i < 20; i++) tick();
    chk("sat_stall", s_stall_cnt, 15);
    chk("sat_req_wr", s_req_wr, 1);
    s_grant_wr = 1;
    #1;
    chk("sat_wr_en", s_mem_wr_en, 1);
    tick();
    s_grant_wr = 0;
    chk("sat_rsp_valid", {s_rsp_valid, s_rsp_err}, 2'b10);
    s_rsp_ready = 1;
    tick();
    s_rsp_ready = 0;
    chk("sat_idle", s_cmd_ready, 1);
    chk("sat_stall_held", s_stall_cnt, 15);

    txn(1'b1, 24'h14, garbage(), 3'd4, 2, 0, 1'b0);
    txn(1'b0, 24'h14, '0, 3'd0, 0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
